// File: rtl/wb_spi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_spi_bridge_if
// Description : Wishbone classic bus bundle between a bus master and the
//               wb_spi_bridge slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_spi_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wb_spi_bridge
// Description : Wishbone classic slave turning bus cycles into single-cycle
//               strobes for the SPI core, with ack timeout and error report.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_spi_bridge #(
    parameter int TIMEOUT = 15
) (
    input  wire               clk,
    input  wire               rst,
    wb_spi_bridge_if.slave    wb,
    output logic [10:0]       spi_din,
    output logic              spi_cmd,
    output logic              spi_wr,
    output logic              spi_rd,
    input  wire  [8:0]        spi_dout,
    input  wire               spi_ack
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_we;
    logic                 r_abort;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [8:0]           r_rdata;
    logic [10:0]          r_cfg;
    logic                 r_sticky;
    logic [10:0]          r_din;
    logic                 r_cmd;
    logic                 r_wr;
    logic                 r_rd;
    logic                 r_ack;
    logic                 r_err;
    logic [31:0]          r_dat_o;

    logic                 w_req;
    logic                 w_core;
    logic                 w_abort;
    logic [31:0]          w_status;
    logic                 w_unused;

    assign w_req    = wb.wb_cyc_i & wb.wb_stb_i;
    // Only CONFIG/TXDATA writes and RXDATA reads reach the core.
    assign w_core   = wb.wb_we_i ? (wb.wb_adr_i[1] == 1'b0) : (wb.wb_adr_i == 2'd2);
    assign w_abort  = r_abort | ~wb.wb_cyc_i;
    assign w_status = {15'b0, r_sticky, 5'b0, r_cfg};
    assign w_unused = ^{wb.wb_dat_i[31:17], wb.wb_dat_i[15:11]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_abort  <= 1'b0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_cfg    <= '0;
            r_sticky <= 1'b0;
            r_din    <= '0;
            r_cmd    <= 1'b0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat_o  <= '0;
        end else begin
            r_cmd   <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= '0;
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_req) begin
                        if (w_core) begin
                            r_state <= S_ISSUE;
                            r_we    <= wb.wb_we_i;
                            if (wb.wb_we_i) r_din <= wb.wb_dat_i[10:0];
                            r_cmd   <= wb.wb_we_i & (wb.wb_adr_i == 2'd0);
                            r_wr    <= wb.wb_we_i & (wb.wb_adr_i == 2'd1);
                            r_rd    <= ~wb.wb_we_i;
                        end else begin
                            r_state <= S_RESP;
                            r_ack   <= 1'b1;
                            if (wb.wb_adr_i == 2'd3) begin
                                if (!wb.wb_we_i)        r_dat_o  <= w_status;
                                else if (wb.wb_dat_i[16]) r_sticky <= 1'b0;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    // Core read data is only valid while the strobe is high.
                    if (r_rd)  r_rdata <= spi_dout;
                    if (r_cmd) r_cfg   <= r_din;
                    if (!wb.wb_cyc_i) r_abort <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_ack) begin
                        r_state <= S_RESP;
                        r_ack   <= ~w_abort;
                        if (!r_we && !w_abort) r_dat_o <= {23'b0, r_rdata};
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state  <= S_RESP;
                        r_err    <= ~w_abort;
                        r_sticky <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spi_din     = r_din;
    assign spi_cmd     = r_cmd;
    assign spi_wr      = r_wr;
    assign spi_rd      = r_rd;
    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign wb.wb_dat_o = r_dat_o;

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_spi_bridge
// Description : Randomized scoreboard bench for wb_spi_bridge with a behavioural
//               register/core model and a programmable SPI core responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_spi_bridge;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] spi_din;
    logic        spi_cmd, spi_wr, spi_rd, spi_ack;
    logic [8:0]  spi_dout;

    always #5 clk = ~clk;

    wb_spi_bridge_if bus();

    wb_spi_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (bus),
        .spi_din  (spi_din),
        .spi_cmd  (spi_cmd),
        .spi_wr   (spi_wr),
        .spi_rd   (spi_rd),
        .spi_dout (spi_dout),
        .spi_ack  (spi_ack)
    );

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
        int          cycle;
    } resp_t;

    typedef struct {
        int          kind;   // 0 cmd, 1 wr, 2 rd
        logic [10:0] din;
        int          cycle;
    } strb_t;

    resp_t resp_q[$];
    strb_t strb_q[$];

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    // Behavioural model of the bridge's visible state.
    logic [10:0] m_cfg    = '0;
    logic [10:0] m_din    = '0;
    bit          m_sticky = 1'b0;

    // Responder programming: ack delay in cycles after the strobe (0 = never).
    int          ack_delay = 1;
    logic [8:0]  core_rdata = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SPI core responder.
    initial begin
        spi_ack  = 1'b0;
        spi_dout = '0;
        forever begin
            @(negedge clk);
            if (spi_cmd || spi_wr || spi_rd) begin
                if (spi_rd) spi_dout = core_rdata;
                @(posedge clk); #1;
                spi_dout = 9'($urandom);
                if (ack_delay > 0) begin
                    for (int i = 1; i < ack_delay; i++) begin
                        @(posedge clk); #1;
                    end
                    spi_ack = 1'b1;
                    @(posedge clk); #1;
                    spi_ack = 1'b0;
                end
            end else begin
                spi_dout = 9'($urandom);
            end
        end
    end

    // Strobe monitor.
    initial begin
        strb_t s;
        int    kind;
        int    n;
        forever begin
            @(negedge clk);
            if (!rst && (spi_cmd || spi_wr || spi_rd)) begin
                tests++;
                n    = int'(spi_cmd) + int'(spi_wr) + int'(spi_rd);
                kind = spi_cmd ? 0 : (spi_wr ? 1 : 2);
                if (strb_q.size() == 0) begin
                    fails++;
                    $display("FAIL strobe_unexpected: kind=%0d din=%h cycle=%0d, required none", kind, spi_din, cyc_cnt);
                end else begin
                    s = strb_q.pop_front();
                    if (n != 1 || kind != s.kind || spi_din !== s.din || cyc_cnt != s.cycle) begin
                        fails++;
                        $display("FAIL strobe: count=%0d kind=%0d din=%h cycle=%0d, required count=1 kind=%0d din=%h cycle=%0d",
                                 n, kind, spi_din, cyc_cnt, s.kind, s.din, s.cycle);
                    end
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst && (bus.wb_ack_o || bus.wb_err_o)) begin
                tests++;
                if (bus.wb_ack_o && bus.wb_err_o) begin
                    fails++;
                    $display("FAIL resp_both: ack=1 err=1, required exactly one");
                end else if (resp_q.size() == 0) begin
                    fails++;
                    $display("FAIL resp_unexpected: ack=%b err=%b cycle=%0d, required no pulse",
                             bus.wb_ack_o, bus.wb_err_o, cyc_cnt);
                end else begin
                    r = resp_q.pop_front();
                    if (bus.wb_err_o != r.is_err || cyc_cnt != r.cycle ||
                        (r.chk_data && bus.wb_dat_o !== r.data)) begin
                        fails++;
                        $display("FAIL resp: err=%b cycle=%0d dat=%h, required err=%b cycle=%0d dat=%h (checked=%0d)",
                                 bus.wb_err_o, cyc_cnt, bus.wb_dat_o, r.is_err, r.cycle, r.data, r.chk_data);
                    end
                end
            end
        end
    end

    // One bus transfer; the expected core strobe and bus response are queued
    // from the model before the request goes out.
    task automatic xfer(input bit we, input logic [1:0] adr, input logic [31:0] dat,
                        input int d, input bit abort, input logic [8:0] rdv);
        bit    core;
        int    k;
        int    n;
        resp_t r;
        strb_t s;
        @(posedge clk); #1;
        k          = cyc_cnt;
        core       = (we && adr <= 2'd1) || (!we && adr == 2'd2);
        ack_delay  = d;
        core_rdata = rdv;
        r.is_err   = 1'b0;
        r.chk_data = 1'b0;
        r.data     = '0;
        if (!core) begin
            abort   = 1'b0;
            r.cycle = k + 1;
            if (!we) begin
                r.chk_data = 1'b1;
                r.data     = (adr == 2'd3) ? {15'b0, m_sticky, 5'b0, m_cfg} : 32'h0;
            end
            if (we && adr == 2'd3 && dat[16]) m_sticky = 1'b0;
        end else begin
            if (we) m_din = dat[10:0];
            s.kind  = we ? int'(adr) : 2;
            s.din   = m_din;
            s.cycle = k + 1;
            strb_q.push_back(s);
            if (we && adr == 2'd0) m_cfg = dat[10:0];
            if (d >= 1 && d <= TIMEOUT) begin
                r.cycle = k + 2 + d;
                if (!we) begin
                    r.chk_data = 1'b1;
                    r.data     = {23'b0, rdv};
                end
            end else begin
                r.is_err = 1'b1;
                r.cycle  = k + 2 + TIMEOUT;
                m_sticky = 1'b1;
            end
        end
        if (!abort) resp_q.push_back(r);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        if (abort) begin
            repeat (2) @(posedge clk);
            #1;
            bus.wb_cyc_i = 1'b0;
            bus.wb_stb_i = 1'b0;
            repeat (TIMEOUT + 6) @(posedge clk);
        end else begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!(bus.wb_ack_o || bus.wb_err_o) && n < 40);
            if (!(bus.wb_ack_o || bus.wb_err_o)) begin
                tests++;
                fails++;
                $display("FAIL xfer_timeout: no ack/err after %0d cycles, required a response", n);
            end
            bus.wb_cyc_i = 1'b0;
            bus.wb_stb_i = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || bus.wb_dat_o !== 32'h0 ||
            spi_cmd !== 1'b0 || spi_wr !== 1'b0 || spi_rd !== 1'b0 || spi_din !== 11'h0) begin
            fails++;
            $display("FAIL %s: ack=%b err=%b dat=%h cmd=%b wr=%b rd=%b din=%h, required all 0",
                     name, bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, spi_cmd, spi_wr, spi_rd, spi_din);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int       sel;
        int       d;
        bit       we;
        bit       ab;
        logic [1:0] adr;
        strb_t    s;

        rst          = 1'b1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst = 1'b0;

        // Directed scenarios.
        xfer(1, 2'd0, 32'h0000_00F9, 1, 0, 9'h0);
        xfer(0, 2'd3, 32'h0,         1, 0, 9'h0);
        xfer(1, 2'd1, 32'h0000_01A5, 1, 0, 9'h0);
        xfer(0, 2'd2, 32'h0,         1, 0, 9'h03C);
        xfer(0, 2'd2, 32'h0,         1, 0, 9'h100);
        xfer(1, 2'd1, 32'h0000_00AA, 0, 0, 9'h0);
        xfer(0, 2'd3, 32'h0,         1, 0, 9'h0);
        xfer(1, 2'd3, 32'h0001_0000, 1, 0, 9'h0);
        xfer(0, 2'd3, 32'h0,         1, 0, 9'h0);
        xfer(1, 2'd1, 32'h0000_0155, TIMEOUT, 0, 9'h0);
        xfer(1, 2'd1, 32'h0000_0066, TIMEOUT + 1, 0, 9'h0);
        xfer(1, 2'd1, 32'h0000_0077, 1, 1, 9'h0);
        xfer(0, 2'd2, 32'h0,         1, 0, 9'h0A5);
        xfer(0, 2'd0, 32'h0,         1, 0, 9'h0);
        xfer(0, 2'd1, 32'h0,         1, 0, 9'h0);
        xfer(1, 2'd2, 32'hFFFF_FFFF, 1, 0, 9'h0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom_range(0, 1));
            adr = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel <= 6)      d = $urandom_range(1, 3);
            else if (sel == 7) d = 0;
            else if (sel == 8) d = $urandom_range(TIMEOUT, TIMEOUT + 1);
            else               d = $urandom_range(4, TIMEOUT - 1);
            ab = ($urandom_range(0, 9) == 0);
            xfer(we, adr, $urandom, d, ab, 9'($urandom));
        end

        // Reset while waiting for a core ack that never comes.
        xfer(1, 2'd0, 32'h0000_0123, 1, 0, 9'h0);
        @(posedge clk); #1;
        ack_delay = 0;
        m_din     = 11'h0F0;
        s.kind    = 1;
        s.din     = m_din;
        s.cycle   = cyc_cnt + 1;
        strb_q.push_back(s);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 2'd1;
        bus.wb_dat_i = 32'h0000_00F0;
        repeat (4) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b0;
        m_cfg    = '0;
        m_din    = '0;
        m_sticky = 1'b0;
        check_idle_outputs("reset_mid_wait");
        xfer(0, 2'd3, 32'h0, 1, 0, 9'h0);
        xfer(1, 2'd1, 32'h0000_005A, 2, 0, 9'h0);

        repeat (TIMEOUT + 5) @(posedge clk);
        tests++;
        if (resp_q.size() != 0 || strb_q.size() != 0) begin
            fails++;
            $display("FAIL queues_drained: resp=%0d strobe=%0d pending, required 0 and 0",
                     resp_q.size(), strb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
